// File: rtl/pdp8_mem_responder_if.sv
// pdp8_mem_responder_if
// CPU <-> memory handshake bundle.
//   addr, wdata          : CPU address / write data (from the sel_addr / sel_data muxes)
//   mem_read, mem_write  : level requests, held by the CPU until mem_valid
//   mem_valid            : one-cycle completion pulse from the responder
//   rdata                : read data, valid while mem_valid=1 and held afterwards
//   err                  : sticky protocol-error flag (read and write both requested)
// Handshake: a request is accepted on the first edge it is seen high while the
// responder is idle; it must stay high until mem_valid, and dropping it early
// aborts the access. mem_valid is a registered single-cycle pulse.
interface pdp8_mem_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output addr, wdata, mem_read, mem_write,
        input  mem_valid, rdata, err
    );

    modport slave (
        input  addr, wdata, mem_read, mem_write,
        output mem_valid, rdata, err
    );
endinterface

// File: rtl/pdp8_mem_responder.sv
// pdp8_mem_responder
// Responder end of the PDP-8 CPU memory handshake: 2**ADDR_WIDTH x DATA_WIDTH
// main memory with WAIT_CYCLES wait states, plus a front-panel deposit port.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)       : CPU handshake (addr, wdata, mem_read, mem_write,
//                       mem_valid, rdata, err)
//   ld_we/addr/data   : front-panel deposit request
//   ld_ack            : one-cycle deposit-done pulse
//   dbg_state         : current FSM state (0=IDLE, 1=WAIT, 2=ACK)
module pdp8_mem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pdp8_mem_responder_if.slave   bus,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ack,
    output logic [1:0]            dbg_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;    // latched op: 1 = write
    logic                  bad_q, bad_d;  // latched op was a read+write collision
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  ld_ack_q, ld_ack_d;

    // Array access happens on the edge entering ACK. With zero wait states
    // that edge is also the accepting edge, so the access fields are muxed
    // between the live bus and the latched copies.
    logic                  enter_ack;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_wr;
    logic                  acc_bad;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic req;
    logic both;
    assign req  = bus.mem_read | bus.mem_write;
    assign both = bus.mem_read & bus.mem_write;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        bad_d     = bad_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ld_ack_d  = 1'b0;
        enter_ack = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wr    = wr_q;
        acc_bad   = bad_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // CPU request wins over a deposit in the same cycle.
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    wr_d    = bus.mem_write;
                    bad_d   = both;
                    if (both) err_d = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                        acc_addr  = bus.addr;
                        acc_wdata = bus.wdata;
                        acc_wr    = bus.mem_write;
                        acc_bad   = both;
                    end
                end else if (ld_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_addr;
                    mem_wdata = ld_data;
                    ld_ack_d  = 1'b1;
                end
            end
            S_WAIT: begin
                // Dropping the request aborts the access with no side effects.
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                // Request is not re-sampled here; a held request is taken as
                // a new one in IDLE with the then-current address.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A collided read+write completes the handshake without touching
        // the array or rdata.
        if (enter_ack && !acc_bad) begin
            if (acc_wr) begin
                mem_we    = 1'b1;
                mem_waddr = acc_addr;
                mem_wdata = acc_wdata;
            end else begin
                rdata_d = mem[acc_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            bad_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ld_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            bad_q    <= bad_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ld_ack_q <= ld_ack_d;
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.mem_valid = (state_q == S_ACK);
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign ld_ack        = ld_ack_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_pdp8_mem_responder.sv
module tb_pdp8_mem_responder;
    localparam int AW = 12;
    localparam int DW = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic rst_n3;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Three instances cover wait-state counts 2, 0 and 3.
    pdp8_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
    pdp8_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    pdp8_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    logic          ld_we2, ld_we0, ld_we3;
    logic [AW-1:0] ld_addr2, ld_addr0, ld_addr3;
    logic [DW-1:0] ld_data2, ld_data0, ld_data3;
    logic          ld_ack2, ld_ack0, ld_ack3;
    logic [1:0]    st2, st0, st3;

    pdp8_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .ld_we(ld_we2), .ld_addr(ld_addr2), .ld_data(ld_data2),
        .ld_ack(ld_ack2), .dbg_state(st2));
    pdp8_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .ld_we(ld_we0), .ld_addr(ld_addr0), .ld_data(ld_data0),
        .ld_ack(ld_ack0), .dbg_state(st0));
    pdp8_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .bus(bus3.slave),
        .ld_we(ld_we3), .ld_addr(ld_addr3), .ld_data(ld_data3),
        .ld_ack(ld_ack3), .dbg_state(st3));

    // ---------------- driver helpers ----------------
    task automatic drive(input int w, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (w)
            0: begin bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = d; end
            2: begin bus2.mem_read = rd; bus2.mem_write = wr; bus2.addr = a; bus2.wdata = d; end
            default: begin bus3.mem_read = rd; bus3.mem_write = wr; bus3.addr = a; bus3.wdata = d; end
        endcase
    endtask

    task automatic drive_ld(input int w, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (w)
            0: begin ld_we0 = we; ld_addr0 = a; ld_data0 = d; end
            2: begin ld_we2 = we; ld_addr2 = a; ld_data2 = d; end
            default: begin ld_we3 = we; ld_addr3 = a; ld_data3 = d; end
        endcase
    endtask

    function automatic logic valid_of(input int w);
        case (w)
            0: return bus0.mem_valid;
            2: return bus2.mem_valid;
            default: return bus3.mem_valid;
        endcase
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int w);
        case (w)
            0: return bus0.rdata;
            2: return bus2.rdata;
            default: return bus3.rdata;
        endcase
    endfunction

    function automatic logic ldack_of(input int w);
        case (w)
            0: return ld_ack0;
            2: return ld_ack2;
            default: return ld_ack3;
        endcase
    endfunction

    // One CPU access: request presented at a negedge, held until mem_valid.
    // lat = number of rising edges from presentation to mem_valid seen high.
    // width = 1 if mem_valid is low again one edge later.
    task automatic access(input int w, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd_o, output int lat, output int width);
        @(negedge clk);
        drive(w, rd, wr, a, d);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (valid_of(w)) break;
        end
        rd_o = rdata_of(w);
        drive(w, 1'b0, 1'b0, a, d);
        @(posedge clk); #1;
        width = valid_of(w) ? 2 : 1;
    endtask

    task automatic deposit(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        @(negedge clk);
        drive_ld(w, 1'b1, a, d);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ldack_of(w) && n < 10);
        drive_ld(w, 1'b0, '0, '0);
        total_cnt++;
        if (n !== 1) $display("FAIL deposit_latency dut%0d: got %0d edges, want 1", w, n);
        else pass_cnt++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total_cnt++;
        if (bus2.mem_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus2.mem_valid); else pass_cnt++;
        total_cnt++;
        if (bus2.rdata !== 12'o0000) $display("FAIL reset_rdata: got %o want 0", bus2.rdata); else pass_cnt++;
        total_cnt++;
        if (bus2.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus2.err); else pass_cnt++;
        total_cnt++;
        if (ld_ack2 !== 1'b0) $display("FAIL reset_ld_ack: got %b want 0", ld_ack2); else pass_cnt++;
        total_cnt++;
        if (st2 !== 2'd0) $display("FAIL reset_state: got %0d want 0", st2); else pass_cnt++;
        total_cnt++;
        if (bus0.mem_valid !== 1'b0 || st0 !== 2'd0)
            $display("FAIL reset_dut0: got valid=%b state=%0d want 0/0", bus0.mem_valid, st0);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] r;
        int lat, width;
        access(2, 1'b0, 1'b1, 12'o0200, 12'o1234, r, lat, width);
        total_cnt++;
        if (lat !== 3) $display("FAIL wr_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++;
        if (width !== 1) $display("FAIL wr_pulse_width: got %0d want 1", width); else pass_cnt++;
        total_cnt++;
        if (r !== 12'o0000) $display("FAIL wr_rdata_unchanged: got %o want 0", r); else pass_cnt++;
        access(2, 1'b1, 1'b0, 12'o0200, 12'o0000, r, lat, width);
        total_cnt++;
        if (lat !== 3) $display("FAIL rd_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++;
        if (r !== 12'o1234) $display("FAIL rd_data: got %o want 1234", r); else pass_cnt++;
        total_cnt++;
        if (width !== 1) $display("FAIL rd_pulse_width: got %0d want 1", width); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int p1, p2;
        logic [DW-1:0] d1, d2;
        deposit(0, 12'o0010, 12'o4321);
        deposit(0, 12'o0011, 12'o1357);
        p1 = 0; p2 = 0; d1 = '0; d2 = '0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 12'o0010, 12'o0000);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (bus0.mem_valid) begin
                if (p1 == 0) begin
                    p1 = cyc; d1 = bus0.rdata;
                    bus0.addr = 12'o0011;  // read stays high through ACK
                end else begin
                    p2 = cyc; d2 = bus0.rdata;
                    break;
                end
            end
        end
        drive(0, 1'b0, 1'b0, 12'o0000, 12'o0000);
        total_cnt++;
        if (p1 !== 1) $display("FAIL b2b_first_latency: got %0d want 1", p1); else pass_cnt++;
        total_cnt++;
        if (p2 - p1 !== 2) $display("FAIL b2b_spacing: got %0d want 2", p2 - p1); else pass_cnt++;
        total_cnt++;
        if (d1 !== 12'o4321) $display("FAIL b2b_data1: got %o want 4321", d1); else pass_cnt++;
        total_cnt++;
        if (d2 !== 12'o1357) $display("FAIL b2b_data2: got %o want 1357", d2); else pass_cnt++;
    endtask

    task automatic test_isz();
        logic [DW-1:0] r;
        int lat, width;
        deposit(2, 12'o0300, 12'o7777);
        access(2, 1'b1, 1'b0, 12'o0300, 12'o0000, r, lat, width);
        total_cnt++;
        if (r !== 12'o7777) $display("FAIL isz_old_data: got %o want 7777", r); else pass_cnt++;
        access(2, 1'b0, 1'b1, 12'o0300, 12'o0000, r, lat, width);
        total_cnt++;
        if (r !== 12'o7777) $display("FAIL isz_rdata_hold: got %o want 7777", r); else pass_cnt++;
        access(2, 1'b1, 1'b0, 12'o0300, 12'o0000, r, lat, width);
        total_cnt++;
        if (r !== 12'o0000) $display("FAIL isz_new_data: got %o want 0", r); else pass_cnt++;
    endtask

    task automatic test_deposit_conflict();
        int cyc, valid_cyc, ack_cyc;
        logic [DW-1:0] rd_seen, r;
        int lat, width, ack_width;
        valid_cyc = 0; ack_cyc = 0; rd_seen = '0;
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 12'o0200, 12'o0000);
        drive_ld(2, 1'b1, 12'o0100, 12'o5001);
        cyc = 0;
        while (cyc < 20 && ack_cyc == 0) begin
            @(posedge clk); #1;
            cyc++;
            if (bus2.mem_valid && valid_cyc == 0) begin
                valid_cyc = cyc;
                rd_seen = bus2.rdata;
                drive(2, 1'b0, 1'b0, 12'o0000, 12'o0000);
            end
            if (ld_ack2) begin
                ack_cyc = cyc;
                drive_ld(2, 1'b0, 12'o0000, 12'o0000);
            end
        end
        @(posedge clk); #1;
        ack_width = ld_ack2 ? 2 : 1;
        total_cnt++;
        if (valid_cyc !== 3) $display("FAIL dep_read_first: got valid at %0d want 3", valid_cyc); else pass_cnt++;
        total_cnt++;
        if (rd_seen !== 12'o1234) $display("FAIL dep_read_data: got %o want 1234", rd_seen); else pass_cnt++;
        total_cnt++;
        if (ack_cyc !== 5) $display("FAIL dep_ack_cycle: got %0d want 5", ack_cyc); else pass_cnt++;
        total_cnt++;
        if (ack_width !== 1) $display("FAIL dep_ack_width: got %0d want 1", ack_width); else pass_cnt++;
        total_cnt++;
        if (st2 !== 2'd0) $display("FAIL dep_state_idle: got %0d want 0", st2); else pass_cnt++;
        access(2, 1'b1, 1'b0, 12'o0100, 12'o0000, r, lat, width);
        total_cnt++;
        if (r !== 12'o5001) $display("FAIL dep_readback: got %o want 5001", r); else pass_cnt++;
    endtask

    task automatic test_protocol_error();
        logic [DW-1:0] r;
        int lat, width;
        access(2, 1'b1, 1'b1, 12'o0200, 12'o0000, r, lat, width);
        total_cnt++;
        if (lat !== 3) $display("FAIL err_valid_pulse: got latency %0d want 3", lat); else pass_cnt++;
        total_cnt++;
        if (r !== 12'o5001) $display("FAIL err_rdata_unchanged: got %o want 5001", r); else pass_cnt++;
        total_cnt++;
        if (bus2.err !== 1'b1) $display("FAIL err_set: got %b want 1", bus2.err); else pass_cnt++;
        access(2, 1'b1, 1'b0, 12'o0200, 12'o0000, r, lat, width);
        total_cnt++;
        if (r !== 12'o1234) $display("FAIL err_mem_unchanged: got %o want 1234", r); else pass_cnt++;
        total_cnt++;
        if (bus2.err !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus2.err); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        logic [DW-1:0] r;
        int lat, width;
        deposit(3, 12'o0400, 12'o0123);
        @(negedge clk);
        drive(3, 1'b0, 1'b1, 12'o0400, 12'o7070);
        @(posedge clk);            // accept -> WAIT
        @(posedge clk); #1;        // still in WAIT
        total_cnt++;
        if (st3 !== 2'd1) $display("FAIL rst_pre_state: got %0d want 1", st3); else pass_cnt++;
        rst_n3 = 1'b0;
        #1;
        total_cnt++;
        if (bus3.mem_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", bus3.mem_valid); else pass_cnt++;
        total_cnt++;
        if (st3 !== 2'd0) $display("FAIL rst_mid_state: got %0d want 0", st3); else pass_cnt++;
        drive(3, 1'b0, 1'b0, 12'o0000, 12'o0000);
        @(negedge clk);
        rst_n3 = 1'b1;
        access(3, 1'b1, 1'b0, 12'o0400, 12'o0000, r, lat, width);
        total_cnt++;
        if (lat !== 4) $display("FAIL rst_read_latency: got %0d want 4", lat); else pass_cnt++;
        total_cnt++;
        if (r !== 12'o0123) $display("FAIL rst_old_contents: got %o want 0123", r); else pass_cnt++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n  = 1'b0;
        rst_n3 = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        drive(3, 1'b0, 1'b0, '0, '0);
        drive_ld(0, 1'b0, '0, '0);
        drive_ld(2, 1'b0, '0, '0);
        drive_ld(3, 1'b0, '0, '0);
        #12;
        test_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        rst_n3 = 1'b1;
        test_write_read();
        test_back_to_back();
        test_isz();
        test_deposit_conflict();
        test_protocol_error();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
